// File: rtl/rv_lsu.sv
// rv_lsu - load/store unit for the rv32i/rv64 core family.
//
// Takes one memory operation from the execute stage, runs it over the
// mem_d_* data bus with a busy-aware handshake, and returns the load
// result sign- or zero-extended to XLEN. Accesses that cross a bus word
// are either split into two aligned beats or rejected with a fault.
//
// Parameters
//   XLEN           data/address width, 32 or 64 (W = XLEN/8 byte lanes)
//   MISALIGN_SPLIT 1 = split word-crossing accesses, 0 = fault when misaligned
//
// Ports
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   req_*              request from execute (valid/ready handshake)
//   resp_*             one-cycle completion pulse with data, tag and fault
//                      (fault: 0 none, 1 misaligned, 2 illegal funct3)
//   mem_d_*            data bus: W-aligned address, lane-positioned write
//                      data and mask, one-cycle strobes, busy inputs
module rv_lsu #(
  parameter int XLEN           = 32,
  parameter bit MISALIGN_SPLIT = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_load_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [XLEN-1:0]   req_addr_i,
  input  logic [XLEN-1:0]   req_wdata_i,
  input  logic [4:0]        req_rd_i,
  output logic              resp_valid_o,
  output logic [XLEN-1:0]   resp_rdata_o,
  output logic [4:0]        resp_rd_o,
  output logic [1:0]        resp_fault_o,
  output logic [XLEN-1:0]   mem_d_addr_o,
  output logic [XLEN-1:0]   mem_d_wdata_o,
  output logic [XLEN/8-1:0] mem_d_wmask_o,
  output logic              mem_d_wstrb_o,
  output logic              mem_d_rstrb_o,
  input  logic [XLEN-1:0]   mem_d_rdata_i,
  input  logic              mem_d_rbusy_i,
  input  logic              mem_d_wbusy_i
);

  localparam int W    = XLEN / 8;
  localparam int OFFW = $clog2(W);

  typedef enum logic [2:0] {IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP} state_e;
  typedef logic [2*XLEN-1:0] dword_t;
  typedef logic [2*W-1:0]    dmask_t;

  state_e            state_q, state_d;
  logic              load_q, load_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [4:0]        rd_q, rd_d;
  logic [1:0]        fault_q, fault_d;
  logic              cross_q, cross_d;
  logic [XLEN-1:0]   rdata0_q, rdata0_d;
  logic [XLEN-1:0]   rdata1_q, rdata1_d;

  // Request decode, evaluated on the raw inputs while IDLE.
  logic [3:0] req_bytes;
  logic [2:0] req_lowmask;
  logic [4:0] req_end;
  logic       req_illegal, req_misal, req_cross;

  always_comb begin
    req_bytes   = 4'd1 << req_funct3_i[1:0];
    req_lowmask = 3'(req_bytes - 4'd1);
    req_illegal = (req_funct3_i == 3'd7) ||
                  ((XLEN == 32) && ((req_funct3_i == 3'd3) || (req_funct3_i == 3'd6)));
    req_misal   = |(req_addr_i[2:0] & req_lowmask);
    req_end     = 5'(req_addr_i[OFFW-1:0]) + 5'(req_bytes);
    req_cross   = req_end > 5'(W);
  end

  // Lane positioning for both beats is done with a double-width shift:
  // the low half is beat 0, the high half is what spills into beat 1.
  // Load assembly uses the same trick in reverse on {beat1, beat0}.
  logic [3:0]      bytes_c;
  logic [OFFW-1:0] off_c;
  logic [XLEN-1:0] base_addr;
  logic [7:0]      size_mask;
  dmask_t          mask_pos;
  dword_t          wdata_pos, rdata_pos;
  logic [XLEN-1:0] rdata_asm, keep_mask, sign_shift, rdata_ext;
  logic [6:0]      sign_idx;
  logic            sign_bit;

  always_comb begin
    bytes_c    = 4'd1 << funct3_q[1:0];
    off_c      = addr_q[OFFW-1:0];
    base_addr  = addr_q & ~XLEN'(W - 1);
    size_mask  = 8'((9'd1 << bytes_c) - 9'd1);
    mask_pos   = dmask_t'(size_mask) << off_c;
    wdata_pos  = dword_t'(wdata_q) << {off_c, 3'b000};
    rdata_pos  = {rdata1_q, rdata0_q} >> {off_c, 3'b000};
    rdata_asm  = rdata_pos[XLEN-1:0];
    // A shift of XLEN or more yields zero, so a full-width access keeps all bits.
    keep_mask  = ~({XLEN{1'b1}} << {bytes_c, 3'b000});
    sign_idx   = {bytes_c, 3'b000} - 7'd1;
    sign_shift = rdata_asm >> sign_idx;
    sign_bit   = ~funct3_q[2] & sign_shift[0];
    rdata_ext  = (rdata_asm & keep_mask) | ({XLEN{sign_bit}} & ~keep_mask);
  end

  // Busy line that matters for the operation in flight.
  logic busy;
  assign busy = load_q ? mem_d_rbusy_i : mem_d_wbusy_i;

  // State and request registers; reset abandons any access in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      load_q   <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_q     <= 5'd0;
      fault_q  <= 2'd0;
      cross_q  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      load_q   <= load_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      fault_q  <= fault_d;
      cross_q  <= cross_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Next-state logic. Faults bypass the bus and go straight to RESP.
  // With splitting disabled any misalignment faults, so a beat-1 pass
  // only ever happens in split mode.
  always_comb begin
    state_d  = state_q;
    load_d   = load_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rd_d     = rd_q;
    fault_d  = fault_q;
    cross_d  = cross_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          load_d   = req_load_i;
          funct3_d = req_funct3_i;
          addr_d   = req_addr_i;
          wdata_d  = req_wdata_i;
          rd_d     = req_rd_i;
          rdata0_d = '0;
          rdata1_d = '0;
          cross_d  = req_cross && MISALIGN_SPLIT;
          if (req_illegal) begin
            fault_d = 2'd2;
            state_d = RESP;
          end else if (req_misal && !MISALIGN_SPLIT) begin
            fault_d = 2'd1;
            state_d = RESP;
          end else begin
            fault_d = 2'd0;
            state_d = ISSUE0;
          end
        end
      end
      ISSUE0: state_d = WAIT0;
      WAIT0: begin
        if (!busy) begin
          rdata0_d = mem_d_rdata_i;
          state_d  = cross_q ? ISSUE1 : RESP;
        end
      end
      ISSUE1: state_d = WAIT1;
      WAIT1: begin
        if (!busy) begin
          rdata1_d = mem_d_rdata_i;
          state_d  = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs are decoded from state so they drop at once on reset and
  // stay stable from ISSUE through the end of the matching WAIT.
  always_comb begin
    mem_d_addr_o  = '0;
    mem_d_wdata_o = '0;
    mem_d_wmask_o = '0;
    mem_d_wstrb_o = 1'b0;
    mem_d_rstrb_o = 1'b0;
    case (state_q)
      ISSUE0, WAIT0: begin
        mem_d_addr_o = base_addr;
        if (!load_q) begin
          mem_d_wdata_o = wdata_pos[XLEN-1:0];
          mem_d_wmask_o = mask_pos[W-1:0];
        end
      end
      ISSUE1, WAIT1: begin
        mem_d_addr_o = base_addr + XLEN'(W);
        if (!load_q) begin
          mem_d_wdata_o = wdata_pos[2*XLEN-1:XLEN];
          mem_d_wmask_o = mask_pos[2*W-1:W];
        end
      end
      default: ;
    endcase
    if ((state_q == ISSUE0) || (state_q == ISSUE1)) begin
      mem_d_rstrb_o = load_q;
      mem_d_wstrb_o = ~load_q;
    end
  end

  // Response outputs are zero outside RESP; data only for fault-free loads.
  always_comb begin
    req_ready_o  = (state_q == IDLE);
    resp_valid_o = (state_q == RESP);
    resp_rd_o    = (state_q == RESP) ? rd_q : 5'd0;
    resp_fault_o = (state_q == RESP) ? fault_q : 2'd0;
    resp_rdata_o = ((state_q == RESP) && load_q && (fault_q == 2'd0)) ? rdata_ext : '0;
  end

endmodule

// File: tb/tb_rv_lsu.sv
// tb_rv_lsu - directed bench for rv_lsu.
// Three instances: 32-bit split mode, 32-bit fault mode, 64-bit split mode.
// Request inputs are shared; only the selected instance sees req_valid.
module tb_rv_lsu;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic [2:0]  vld = 3'b000;
  logic        reqLoad = 1'b0;
  logic [2:0]  reqF3 = 3'd0;
  logic [63:0] reqAddr = '0;
  logic [63:0] reqWdata = '0;
  logic [4:0]  reqRd = 5'd0;
  logic        rbusy = 1'b0;
  logic        wbusy = 1'b0;
  int          sel = 0;

  int vecs = 0;
  int miss = 0;

  logic [31:0] mem32 [0:255];
  logic [63:0] mem64 [0:15];

  logic        rdy0, rv0, ws0, rs0, rdy1, rv1, ws1, rs1, rdy2, rv2, ws2, rs2;
  logic [31:0] rdat0, ma0, mwd0, mrd0, rdat1, ma1, mwd1, mrd1;
  logic [63:0] rdat2, ma2, mwd2, mrd2;
  logic [4:0]  rrd0, rrd1, rrd2;
  logic [1:0]  flt0, flt1, flt2;
  logic [3:0]  mwm0, mwm1;
  logic [7:0]  mwm2;

  always #5 clk = ~clk;

  assign mrd0 = mem32[ma0[9:2]];
  assign mrd1 = mem32[ma1[9:2]];
  assign mrd2 = mem64[ma2[6:3]];

  rv_lsu #(.XLEN(32), .MISALIGN_SPLIT(1'b1)) dut0 (
    .clk_i(clk), .rst_ni(rstN), .req_valid_i(vld[0]), .req_ready_o(rdy0),
    .req_load_i(reqLoad), .req_funct3_i(reqF3), .req_addr_i(reqAddr[31:0]),
    .req_wdata_i(reqWdata[31:0]), .req_rd_i(reqRd), .resp_valid_o(rv0),
    .resp_rdata_o(rdat0), .resp_rd_o(rrd0), .resp_fault_o(flt0),
    .mem_d_addr_o(ma0), .mem_d_wdata_o(mwd0), .mem_d_wmask_o(mwm0),
    .mem_d_wstrb_o(ws0), .mem_d_rstrb_o(rs0), .mem_d_rdata_i(mrd0),
    .mem_d_rbusy_i(rbusy), .mem_d_wbusy_i(wbusy));

  rv_lsu #(.XLEN(32), .MISALIGN_SPLIT(1'b0)) dut1 (
    .clk_i(clk), .rst_ni(rstN), .req_valid_i(vld[1]), .req_ready_o(rdy1),
    .req_load_i(reqLoad), .req_funct3_i(reqF3), .req_addr_i(reqAddr[31:0]),
    .req_wdata_i(reqWdata[31:0]), .req_rd_i(reqRd), .resp_valid_o(rv1),
    .resp_rdata_o(rdat1), .resp_rd_o(rrd1), .resp_fault_o(flt1),
    .mem_d_addr_o(ma1), .mem_d_wdata_o(mwd1), .mem_d_wmask_o(mwm1),
    .mem_d_wstrb_o(ws1), .mem_d_rstrb_o(rs1), .mem_d_rdata_i(mrd1),
    .mem_d_rbusy_i(rbusy), .mem_d_wbusy_i(wbusy));

  rv_lsu #(.XLEN(64), .MISALIGN_SPLIT(1'b1)) dut2 (
    .clk_i(clk), .rst_ni(rstN), .req_valid_i(vld[2]), .req_ready_o(rdy2),
    .req_load_i(reqLoad), .req_funct3_i(reqF3), .req_addr_i(reqAddr),
    .req_wdata_i(reqWdata), .req_rd_i(reqRd), .resp_valid_o(rv2),
    .resp_rdata_o(rdat2), .resp_rd_o(rrd2), .resp_fault_o(flt2),
    .mem_d_addr_o(ma2), .mem_d_wdata_o(mwd2), .mem_d_wmask_o(mwm2),
    .mem_d_wstrb_o(ws2), .mem_d_rstrb_o(rs2), .mem_d_rdata_i(mrd2),
    .mem_d_rbusy_i(rbusy), .mem_d_wbusy_i(wbusy));

  // Observation mux onto the instance under test, widened to 64 bits.
  logic        obReady, obRvalid, obRstrb, obWstrb;
  logic [63:0] obRdata, obAddr, obWdata;
  logic [7:0]  obMask;
  logic [4:0]  obRd;
  logic [1:0]  obFault;

  always_comb begin
    case (sel)
      0: begin
        obReady = rdy0; obRvalid = rv0; obRstrb = rs0; obWstrb = ws0;
        obRdata = 64'(rdat0); obAddr = 64'(ma0); obWdata = 64'(mwd0);
        obMask = 8'(mwm0); obRd = rrd0; obFault = flt0;
      end
      1: begin
        obReady = rdy1; obRvalid = rv1; obRstrb = rs1; obWstrb = ws1;
        obRdata = 64'(rdat1); obAddr = 64'(ma1); obWdata = 64'(mwd1);
        obMask = 8'(mwm1); obRd = rrd1; obFault = flt1;
      end
      default: begin
        obReady = rdy2; obRvalid = rv2; obRstrb = rs2; obWstrb = ws2;
        obRdata = rdat2; obAddr = ma2; obWdata = mwd2;
        obMask = mwm2; obRd = rrd2; obFault = flt2;
      end
    endcase
  end

  // Per-operation record filled in by applyStimulus.
  int          nStrb;
  int          strbCyc [2];
  logic [63:0] strbAddr [2];
  logic [63:0] strbData [2];
  logic [7:0]  strbMask [2];
  logic        strbWrite [2];
  int          respCyc;
  logic [63:0] respData;
  logic [1:0]  respFault;
  logic [4:0]  respRd;
  bit          addrHeld;

  // Issues one request on instance s (accepted at edge T) and records bus
  // beats and the response, counting cycles from T. busyN holds the busy
  // line high for that many cycles after the first strobe.
  task automatic applyStimulus(input int s, input logic ld, input logic [2:0] f3,
                               input logic [63:0] a, input logic [63:0] wd,
                               input logic [4:0] rd, input int busyN);
    @(negedge clk);
    sel = s; reqLoad = ld; reqF3 = f3; reqAddr = a; reqWdata = wd; reqRd = rd;
    vld = 3'b000; vld[s] = 1'b1;
    nStrb = 0; respCyc = -1; respData = '0; respFault = 2'd0; respRd = 5'd0;
    addrHeld = 1'b1;
    for (int i = 0; i < 2; i++) begin
      strbCyc[i] = -1; strbAddr[i] = '0; strbData[i] = '0; strbMask[i] = '0; strbWrite[i] = 1'b0;
    end
    @(posedge clk);
    for (int k = 1; k <= 20 && respCyc < 0; k++) begin
      @(negedge clk);
      vld = 3'b000;
      rbusy = (k >= 2) && (k <= busyN + 1);
      wbusy = rbusy;
      if (obRstrb || obWstrb) begin
        if (nStrb < 2) begin
          strbCyc[nStrb] = k; strbAddr[nStrb] = obAddr; strbData[nStrb] = obWdata;
          strbMask[nStrb] = obMask; strbWrite[nStrb] = obWstrb;
        end
        nStrb++;
      end else if (nStrb > 0 && nStrb <= 2 && !obRvalid && obAddr !== strbAddr[nStrb-1]) begin
        addrHeld = 1'b0;
      end
      if (obRvalid) begin
        respCyc = k; respData = obRdata; respFault = obFault; respRd = obRd;
      end
    end
    rbusy = 1'b0; wbusy = 1'b0;
  endtask

  task automatic test_reset;
    sel = 0;
    #1;
    vecs++; if (obReady !== 1'b1) begin miss++; $display("[TB] FAIL reset_ready: got %b want 1", obReady); end
    vecs++; if (obRvalid !== 1'b0) begin miss++; $display("[TB] FAIL reset_rvalid: got %b want 0", obRvalid); end
    vecs++; if ((obRstrb | obWstrb) !== 1'b0) begin miss++; $display("[TB] FAIL reset_strb: got %b%b want 00", obRstrb, obWstrb); end
    vecs++; if (obAddr !== 64'h0) begin miss++; $display("[TB] FAIL reset_addr: got %h want 0", obAddr); end
    repeat (2) @(negedge clk);
    rstN = 1'b1;
  endtask

  task automatic test_lw_aligned;
    mem32[64] = 32'h8899AABB;
    applyStimulus(0, 1'b1, 3'd2, 64'h100, 64'h0, 5'd9, 0);
    vecs++; if (nStrb !== 1) begin miss++; $display("[TB] FAIL lw_nstrb: got %0d want 1", nStrb); end
    vecs++; if (strbCyc[0] !== 1 || strbWrite[0] !== 1'b0) begin miss++; $display("[TB] FAIL lw_strb: got cyc %0d wr %b want cyc 1 rd", strbCyc[0], strbWrite[0]); end
    vecs++; if (strbAddr[0] !== 64'h100) begin miss++; $display("[TB] FAIL lw_addr: got %h want 100", strbAddr[0]); end
    vecs++; if (respCyc !== 3) begin miss++; $display("[TB] FAIL lw_lat: got %0d want 3", respCyc); end
    vecs++; if (respData !== 64'h8899AABB) begin miss++; $display("[TB] FAIL lw_data: got %h want 8899aabb", respData); end
    vecs++; if (respFault !== 2'd0 || respRd !== 5'd9) begin miss++; $display("[TB] FAIL lw_resp: got fault %0d rd %0d want 0 9", respFault, respRd); end
  endtask

  task automatic test_byte_loads;
    mem32[64] = 32'h80112233;
    applyStimulus(0, 1'b1, 3'd0, 64'h103, 64'h0, 5'd1, 0);
    vecs++; if (respData !== 64'hFFFFFF80 || respCyc !== 3) begin miss++; $display("[TB] FAIL lb: got %h cyc %0d want ffffff80 cyc 3", respData, respCyc); end
    applyStimulus(0, 1'b1, 3'd4, 64'h103, 64'h0, 5'd2, 0);
    vecs++; if (respData !== 64'h00000080) begin miss++; $display("[TB] FAIL lbu: got %h want 00000080", respData); end
    // misaligned halfword that stays inside the word: one beat, no fault
    applyStimulus(0, 1'b1, 3'd1, 64'h101, 64'h0, 5'd3, 0);
    vecs++; if (respData !== 64'h00001122 || respFault !== 2'd0 || nStrb !== 1 || respCyc !== 3) begin
      miss++; $display("[TB] FAIL lh_inword: got %h f%0d n%0d c%0d want 00001122 f0 n1 c3", respData, respFault, nStrb, respCyc);
    end
  endtask

  task automatic test_store_half;
    applyStimulus(0, 1'b0, 3'd1, 64'h102, 64'h12345678, 5'd4, 0);
    vecs++; if (nStrb !== 1 || strbWrite[0] !== 1'b1 || strbCyc[0] !== 1) begin miss++; $display("[TB] FAIL sh_strb: got n%0d wr %b cyc %0d want n1 wr1 cyc1", nStrb, strbWrite[0], strbCyc[0]); end
    vecs++; if (strbAddr[0] !== 64'h100) begin miss++; $display("[TB] FAIL sh_addr: got %h want 100", strbAddr[0]); end
    vecs++; if (strbMask[0] !== 8'b1100) begin miss++; $display("[TB] FAIL sh_mask: got %b want 1100", strbMask[0]); end
    vecs++; if (strbData[0] !== 64'h56780000) begin miss++; $display("[TB] FAIL sh_wdata: got %h want 56780000", strbData[0]); end
    vecs++; if (respCyc !== 3 || respData !== 64'h0) begin miss++; $display("[TB] FAIL sh_resp: got cyc %0d data %h want 3 0", respCyc, respData); end
  endtask

  task automatic test_split_load;
    mem32[63] = 32'h44332211; mem32[64] = 32'h88776655;
    applyStimulus(0, 1'b1, 3'd2, 64'h0FE, 64'h0, 5'd5, 0);
    vecs++; if (nStrb !== 2 || strbCyc[0] !== 1 || strbCyc[1] !== 3) begin miss++; $display("[TB] FAIL split_ld_beats: got n%0d c%0d/%0d want n2 c1/3", nStrb, strbCyc[0], strbCyc[1]); end
    vecs++; if (strbAddr[0] !== 64'h0FC || strbAddr[1] !== 64'h100) begin miss++; $display("[TB] FAIL split_ld_addr: got %h/%h want 0fc/100", strbAddr[0], strbAddr[1]); end
    vecs++; if (respData !== 64'h66554433 || respCyc !== 5) begin miss++; $display("[TB] FAIL split_ld_data: got %h cyc %0d want 66554433 cyc 5", respData, respCyc); end
    // second beat address wraps around the top of the address space
    mem32[255] = 32'h44332211; mem32[0] = 32'h88776655;
    applyStimulus(0, 1'b1, 3'd2, 64'hFFFFFFFE, 64'h0, 5'd6, 0);
    vecs++; if (strbAddr[0] !== 64'hFFFFFFFC || strbAddr[1] !== 64'h0 || respData !== 64'h66554433) begin
      miss++; $display("[TB] FAIL split_wrap: got %h/%h data %h want fffffffc/0 66554433", strbAddr[0], strbAddr[1], respData);
    end
  endtask

  task automatic test_split_store;
    applyStimulus(0, 1'b0, 3'd2, 64'h0FF, 64'hAABBCCDD, 5'd7, 0);
    vecs++; if (nStrb !== 2 || strbWrite[0] !== 1'b1 || strbWrite[1] !== 1'b1) begin miss++; $display("[TB] FAIL split_st_beats: got n%0d wr %b%b want n2 wr 11", nStrb, strbWrite[0], strbWrite[1]); end
    vecs++; if (strbAddr[0] !== 64'h0FC || strbMask[0] !== 8'b1000 || strbData[0] !== 64'hDD000000) begin
      miss++; $display("[TB] FAIL split_st_b0: got %h %b %h want 0fc 1000 dd000000", strbAddr[0], strbMask[0], strbData[0]);
    end
    vecs++; if (strbAddr[1] !== 64'h100 || strbMask[1] !== 8'b0111 || strbData[1] !== 64'h00AABBCC) begin
      miss++; $display("[TB] FAIL split_st_b1: got %h %b %h want 100 0111 00aabbcc", strbAddr[1], strbMask[1], strbData[1]);
    end
    vecs++; if (respCyc !== 5) begin miss++; $display("[TB] FAIL split_st_lat: got %0d want 5", respCyc); end
  endtask

  task automatic test_busy;
    mem32[128] = 32'hCAFEF00D;
    applyStimulus(0, 1'b1, 3'd2, 64'h200, 64'h0, 5'd8, 3);
    vecs++; if (respCyc !== 6) begin miss++; $display("[TB] FAIL busy_lat: got %0d want 6", respCyc); end
    vecs++; if (addrHeld !== 1'b1 || nStrb !== 1) begin miss++; $display("[TB] FAIL busy_hold: got held %b n%0d want 1 n1", addrHeld, nStrb); end
    vecs++; if (respData !== 64'hCAFEF00D) begin miss++; $display("[TB] FAIL busy_data: got %h want cafef00d", respData); end
  endtask

  task automatic test_reset_in_wait;
    bit seen;
    @(negedge clk);
    sel = 0; reqLoad = 1'b1; reqF3 = 3'd2; reqAddr = 64'h200; vld = 3'b001;
    @(posedge clk);
    @(negedge clk);
    vld = 3'b000; rbusy = 1'b1;
    @(negedge clk);
    rstN = 1'b0;
    #1;
    vecs++; if (obReady !== 1'b1 || obRstrb !== 1'b0 || obAddr !== 64'h0) begin
      miss++; $display("[TB] FAIL rst_wait_now: got rdy %b strb %b addr %h want 1 0 0", obReady, obRstrb, obAddr);
    end
    repeat (2) @(negedge clk);
    rstN = 1'b1; rbusy = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (obRvalid) seen = 1'b1;
    end
    vecs++; if (seen !== 1'b0 || obReady !== 1'b1) begin miss++; $display("[TB] FAIL rst_wait_noresp: got resp %b rdy %b want 0 1", seen, obReady); end
  endtask

  task automatic test_faults;
    applyStimulus(1, 1'b1, 3'd1, 64'h101, 64'h0, 5'd10, 0);
    vecs++; if (respCyc !== 1 || respFault !== 2'd1 || nStrb !== 0 || respRd !== 5'd10) begin
      miss++; $display("[TB] FAIL misal_fault: got c%0d f%0d n%0d rd%0d want c1 f1 n0 rd10", respCyc, respFault, nStrb, respRd);
    end
    applyStimulus(0, 1'b1, 3'd3, 64'h100, 64'h0, 5'd11, 0);
    vecs++; if (respCyc !== 1 || respFault !== 2'd2 || nStrb !== 0 || respData !== 64'h0) begin
      miss++; $display("[TB] FAIL f3_3_fault: got c%0d f%0d n%0d d%h want c1 f2 n0 d0", respCyc, respFault, nStrb, respData);
    end
    applyStimulus(0, 1'b1, 3'd6, 64'h100, 64'h0, 5'd12, 0);
    vecs++; if (respFault !== 2'd2) begin miss++; $display("[TB] FAIL f3_6_fault: got %0d want 2", respFault); end
    applyStimulus(2, 1'b0, 3'd7, 64'h8, 64'h0, 5'd13, 0);
    vecs++; if (respFault !== 2'd2 || nStrb !== 0) begin miss++; $display("[TB] FAIL f3_7_fault64: got f%0d n%0d want f2 n0", respFault, nStrb); end
  endtask

  task automatic test_xlen64;
    mem64[1] = 64'h0123456789ABCDEF;
    mem64[2] = 64'h89ABCDEF00000000;
    applyStimulus(2, 1'b1, 3'd3, 64'h8, 64'h0, 5'd14, 0);
    vecs++; if (respData !== 64'h0123456789ABCDEF || strbAddr[0] !== 64'h8 || respCyc !== 3) begin
      miss++; $display("[TB] FAIL ld64: got %h addr %h c%0d want 0123456789abcdef 8 c3", respData, strbAddr[0], respCyc);
    end
    applyStimulus(2, 1'b1, 3'd2, 64'h14, 64'h0, 5'd15, 0);
    vecs++; if (respData !== 64'hFFFFFFFF89ABCDEF || strbAddr[0] !== 64'h10) begin
      miss++; $display("[TB] FAIL lw64: got %h addr %h want ffffffff89abcdef 10", respData, strbAddr[0]);
    end
    applyStimulus(2, 1'b1, 3'd6, 64'h14, 64'h0, 5'd16, 0);
    vecs++; if (respData !== 64'h0000000089ABCDEF || respFault !== 2'd0) begin
      miss++; $display("[TB] FAIL lwu64: got %h f%0d want 0000000089abcdef f0", respData, respFault);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem32[i] = '0;
    for (int i = 0; i < 16; i++) mem64[i] = '0;
    $display("[TB] rv_lsu directed bench start");
    test_reset;
    test_lw_aligned;
    test_byte_loads;
    test_store_half;
    test_split_load;
    test_split_store;
    test_busy;
    test_reset_in_wait;
    test_faults;
    test_xlen64;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
